dpram_bus_master: RTL and testbench

DPRAM_BUS_MASTER -- requirements
Module: dpram_bus_master

---
 rtl/dpram_bus_pkg.sv | 22 ++
 rtl/dpram_phase_timer.sv | 34 +++
 rtl/dpram_bus_master.sv | 132 +++++++++++++
 tb/tb_dpram_bus_master.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dpram_bus_pkg.sv
// Shared types and constants for the DS1609-style bus master.
//   state_e      : bus sequencer states
//   DEF_ADDR_CYC : default address-phase length (cycles)
//   DEF_ACC_CYC  : default strobe (we_n/oe_n) length (cycles)
//   AD_W         : width of the multiplexed address/data bus
//   CNT_W        : width of the wait-state counter
package dpram_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        TURN,
        ACCESS,
        RECOV
    } state_e;

    localparam int DEF_ADDR_CYC = 1;
    localparam int DEF_ACC_CYC  = 2;
    localparam int AD_W         = 8;
    localparam int CNT_W        = 4;

endpackage

// File: rtl/dpram_phase_timer.sv
// Wait-state counter for one bus phase. Loaded with N-1 on phase entry,
// counts down to 0 and parks there (no wrap).
//   clk, rst_n  : clock, async active-low reset
//   load_i      : load load_val_i this cycle
//   load_val_i  : phase length minus one
//   zero_o      : counter is at 0 (last cycle of the phase)
module dpram_phase_timer
    import dpram_bus_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dpram_bus_master.sv
// Host-side master for a DS1609-style multiplexed dual-port RAM port.
// One command per req/ready handshake: address phase, optional read
// turnaround, strobe phase, one recovery cycle with a done pulse.
//   clk, rst_n        : clock, async active-low reset
//   req, wr           : command request (accepted when req && ready), 1 = write
//   addr, wdata       : command address / write data, captured on accept
//   ready, done       : idle indicator, end-of-command pulse
//   rdata             : last read result
//   ad                : multiplexed address/data bus (tristate)
//   ce_n, we_n, oe_n  : active-low port strobes
module dpram_bus_master
    import dpram_bus_pkg::*;
#(
    parameter int ADDR_CYC = DEF_ADDR_CYC,
    parameter int ACC_CYC  = DEF_ACC_CYC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            wr,
    input  logic [AD_W-1:0] addr,
    input  logic [AD_W-1:0] wdata,
    output logic            ready,
    output logic            done,
    output logic [AD_W-1:0] rdata,
    inout  wire  [AD_W-1:0] ad,
    output logic            ce_n,
    output logic            we_n,
    output logic            oe_n
);

    localparam logic [CNT_W-1:0] ADDR_LD = CNT_W'(ADDR_CYC - 1);
    localparam logic [CNT_W-1:0] ACC_LD  = CNT_W'(ACC_CYC - 1);

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [AD_W-1:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q;
    logic              ce_n_q, we_n_q, oe_n_q, ad_oe_q;
    logic              ce_n_d, we_n_d, oe_n_d, ad_oe_d;
    logic [AD_W-1:0]   ad_out_q, ad_out_d;
    logic              tmr_load, tmr_zero;
    logic [CNT_W-1:0]  tmr_val;

    dpram_phase_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: if (req) begin
                state_d  = ADDR;
                wr_d     = wr;
                addr_d   = addr;
                wdata_d  = wdata;
                tmr_load = 1'b1;
                tmr_val  = ADDR_LD;
            end
            ADDR: if (tmr_zero) begin
                if (wr_q) begin
                    state_d  = ACCESS;
                    tmr_load = 1'b1;
                    tmr_val  = ACC_LD;
                end else begin
                    state_d  = TURN;
                end
            end
            TURN: begin
                state_d  = ACCESS;
                tmr_load = 1'b1;
                tmr_val  = ACC_LD;
            end
            ACCESS: if (tmr_zero) state_d = RECOV;
            RECOV:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Pin values are decoded from the *next* state so every strobe and
        // the bus enable come straight out of a flop, aligned with the state.
        ce_n_d   = (state_d == IDLE) || (state_d == RECOV);
        we_n_d   = !((state_d == ACCESS) && wr_d);
        oe_n_d   = !((state_d == ACCESS) && !wr_d);
        ad_oe_d  = (state_d == ADDR) || ((state_d == ACCESS) && wr_d);
        ad_out_d = (state_d == ADDR) ? addr_d : wdata_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ce_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            ad_oe_q  <= 1'b0;
            ad_out_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ce_n_q   <= ce_n_d;
            we_n_q   <= we_n_d;
            oe_n_q   <= oe_n_d;
            ad_oe_q  <= ad_oe_d;
            ad_out_q <= ad_out_d;
            // Capture read data on the edge closing the last strobe cycle.
            if ((state_q == ACCESS) && !wr_q && tmr_zero)
                rdata_q <= ad;
        end
    end

    assign ad    = ad_oe_q ? ad_out_q : {AD_W{1'bz}};
    assign ce_n  = ce_n_q;
    assign we_n  = we_n_q;
    assign oe_n  = oe_n_q;
    assign ready = (state_q == IDLE);
    assign done  = (state_q == RECOV);
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dpram_bus_master.sv
module tb_dpram_bus_master;
    import dpram_bus_pkg::*;

    localparam int AC  = DEF_ADDR_CYC;
    localparam int XC  = DEF_ACC_CYC;
    localparam int AC2 = 3;
    localparam int XC2 = 5;
    localparam logic [7:0] REL = 8'hFF;   // pulled-up value of a released bus

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance with a RAM device model
    logic       req = 1'b0, wr = 1'b0;
    logic [7:0] addr = '0, wdata = '0, rdata;
    logic       ready, done, ce_n, we_n, oe_n;
    tri1  [7:0] ad;

    dpram_bus_master dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .ad(ad),
        .ce_n(ce_n), .we_n(we_n), .oe_n(oe_n)
    );

    // long-timing instance with a constant-data responder
    logic       req2 = 1'b0, wr2 = 1'b0;
    logic [7:0] addr2 = '0, wdata2 = '0, rdata2;
    logic       ready2, done2, ce_n2, we_n2, oe_n2;
    tri1  [7:0] ad2;

    dpram_bus_master #(.ADDR_CYC(AC2), .ACC_CYC(XC2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .wr(wr2), .addr(addr2), .wdata(wdata2),
        .ready(ready2), .done(done2), .rdata(rdata2), .ad(ad2),
        .ce_n(ce_n2), .we_n(we_n2), .oe_n(oe_n2)
    );

    assign ad2 = (!ce_n2 && !oe_n2) ? 8'hC3 : 8'bz;

    // RAM device: latches the address on the first clocked cycle of ce_n low,
    // writes at the rising edge while we_n is low, drives the bus while oe_n low.
    logic [7:0] ram [256];
    logic [7:0] lat = '0;
    bit         ce_seen = 1'b0;

    assign ad = (!ce_n && !oe_n) ? ram[lat] : 8'bz;

    always @(posedge clk) begin
        if (ce_n) ce_seen <= 1'b0;
        else if (!ce_seen) begin
            ce_seen <= 1'b1;
            lat     <= ad;
        end
        if (!ce_n && !we_n) ram[lat] <= ad;
    end

    // reference model
    logic [7:0] exp_mem [256];
    logic [7:0] last_rd = 8'h00;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one command starting from a negedge inside an IDLE cycle and returns
    // at the negedge of the following IDLE cycle. abort_at >= 0 pulls reset at
    // that cycle of the command instead of completing it.
    task automatic do_cmd(input bit w, input logic [7:0] a, input logic [7:0] d,
                          input int abort_at);
        logic [4:0] es[$];   // {ready, done, ce_n, we_n, oe_n}
        logic [7:0] ea[$];
        chk("idle_pins", {11'd0, ready, done, ce_n, we_n, oe_n}, 16'b10111);
        chk("idle_ad", {8'd0, ad}, {8'd0, REL});
        for (int i = 0; i < AC; i++) begin es.push_back(5'b00011); ea.push_back(a); end
        if (!w) begin es.push_back(5'b00011); ea.push_back(REL); end
        for (int i = 0; i < XC; i++) begin
            es.push_back(w ? 5'b00001 : 5'b00010);
            ea.push_back(w ? d : exp_mem[a]);
        end
        es.push_back(5'b01111); ea.push_back(REL);

        req = 1'b1; wr = w; addr = a; wdata = d;
        for (int i = 0; i < es.size(); i++) begin
            @(negedge clk);
            if (i == abort_at) begin
                req = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_pins", {11'd0, ready, done, ce_n, we_n, oe_n}, 16'b10111);
                chk("rst_ad", {8'd0, ad}, {8'd0, REL});
                chk("rst_rdata", {8'd0, rdata}, 16'h0000);
                last_rd = 8'h00;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            chk($sformatf("pins_c%0d", i), {11'd0, ready, done, ce_n, we_n, oe_n}, {11'd0, es[i]});
            chk($sformatf("ad_c%0d", i), {8'd0, ad}, {8'd0, ea[i]});
            // Inputs are dead after accept; scramble them, including a stray
            // request at 8'h77 in the first strobe cycle.
            wr    = 1'($urandom);
            addr  = 8'($urandom);
            wdata = 8'($urandom);
            req   = (i + 1 < es.size()) ? 1'($urandom) : 1'b0;
            if (i == AC + (w ? 0 : 1)) begin req = 1'b1; addr = 8'h77; end
        end
        if (w) begin
            exp_mem[a] = d;
            chk("ram_write", {8'd0, ram[a]}, {8'd0, d});
            chk("rdata_hold", {8'd0, rdata}, {8'd0, last_rd});
        end else begin
            last_rd = exp_mem[a];
            chk("rdata", {8'd0, rdata}, {8'd0, exp_mem[a]});
        end
        @(negedge clk);
    endtask

    initial begin
        int busy, oe_lo, dn, ovl, bud;
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 8'($urandom);
            exp_mem[i] = ram[i];
        end

        // reset state
        #12;
        chk("reset_pins", {11'd0, ready, done, ce_n, we_n, oe_n}, 16'b10111);
        chk("reset_ad", {8'd0, ad}, {8'd0, REL});
        chk("reset_rdata", {8'd0, rdata}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed write then read of 3C
        do_cmd(1'b1, 8'h3C, 8'hA5, -1);
        do_cmd(1'b0, 8'h3C, 8'h00, -1);
        chk("read_3C", {8'd0, rdata}, 16'h00A5);

        // back-to-back write 00 -> FF, read FF
        do_cmd(1'b1, 8'hFF, 8'h00, -1);
        do_cmd(1'b0, 8'hFF, 8'h5A, -1);
        chk("b2b_rdata", {8'd0, rdata}, 16'h0000);

        // randomized commands
        for (int k = 0; k < 24; k++)
            do_cmd(1'($urandom), 8'($urandom), 8'($urandom), -1);

        // reset in the first strobe cycle of a write to 10; the write must not land
        do_cmd(1'b1, 8'h10, ~exp_mem[8'h10], AC);
        do_cmd(1'b0, 8'h10, 8'h00, -1);

        // long-timing read: busy and strobe widths
        req2 = 1'b1; wr2 = 1'b0; addr2 = 8'($urandom);
        @(negedge clk);
        req2 = 1'b0;
        busy = 0; oe_lo = 0; dn = 0; ovl = 0; bud = 0;
        while (!ready2 && bud < 40) begin
            busy++;
            bud++;
            if (!oe_n2) oe_lo++;
            if (!oe_n2 && !we_n2) ovl++;
            if (done2) dn++;
            @(negedge clk);
        end
        chk("long_busy", 16'(busy), 16'(AC2 + XC2 + 2));
        chk("long_oe", 16'(oe_lo), 16'(XC2));
        chk("long_done", 16'(dn), 16'd1);
        chk("long_overlap", 16'(ovl), 16'd0);
        chk("long_rdata", {8'd0, rdata2}, 16'h00C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
